// File: rtl/data_sync_pkg.sv
// Shared constants and helpers for the multi-channel bus synchroniser.
package data_sync_pkg;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  localparam int unsigned OVR_CNT_W = 8;

  // LSB position of channel ch inside a flattened per-channel bus of width w.
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
    return ch * w;
  endfunction

endpackage

// File: rtl/data_sync_ch.sv
// One channel: enable synchroniser, edge detect, capture register, valid/ready
// handshake and sticky overrun. Optional saturating counter under DATA_SYNC_OVR_CNT_EN.
module data_sync_ch
  import data_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned EDGE_MODE  = EDGE_RISE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  input  logic                 sync_ready,
  input  logic                 ovr_clr,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 sync_valid,
  output logic                 enable_pulse,
  output logic                 overrun
`ifdef DATA_SYNC_OVR_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0] ovr_count
`endif
);

  logic [NUM_STAGES-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic [BUS_WIDTH-1:0]  bus_q, bus_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic                  rise, fall, edge_det, ovr_event;

  always_comb begin
    sync_d    = {sync_q[NUM_STAGES-2:0], bus_enable};
    prev_d    = sync_q[NUM_STAGES-1];
    rise      = sync_q[NUM_STAGES-1] & ~prev_q;
    fall      = ~sync_q[NUM_STAGES-1] & prev_q;
    if (EDGE_MODE == EDGE_BOTH)      edge_det = rise ^ fall;
    else if (EDGE_MODE == EDGE_FALL) edge_det = fall;
    else                             edge_det = rise;
    // A capture that lands on a stalled valid word overwrites it and flags overrun.
    ovr_event = edge_det & valid_q & ~sync_ready;
    bus_d     = edge_det ? unsync_bus : bus_q;
    valid_d   = edge_det | (valid_q & ~sync_ready);
    ovr_d     = ovr_event | (ovr_q & ~ovr_clr);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      bus_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sync_bus     = bus_q;
  assign sync_valid   = valid_q;
  assign enable_pulse = edge_det;
  assign overrun      = ovr_q;

`ifdef DATA_SYNC_OVR_CNT_EN
  logic [OVR_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (ovr_clr)                       cnt_d = {{(OVR_CNT_W-1){1'b0}}, ovr_event};
    else if (ovr_event && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    else                               cnt_d = cnt_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign ovr_count = cnt_q;
`endif

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel bus synchroniser top: NUM_CH independent data_sync_ch instances.
// Optional per-channel overrun counters are built when DATA_SYNC_OVR_CNT_EN is defined.
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned EDGE_MODE  = EDGE_RISE
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           sync_ready,
  input  logic [NUM_CH-1:0]           ovr_clr,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           overrun
`ifdef DATA_SYNC_OVR_CNT_EN
  ,
  output logic [NUM_CH*OVR_CNT_W-1:0] ovr_count
`endif
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    data_sync_ch #(
      .NUM_STAGES(NUM_STAGES),
      .BUS_WIDTH (BUS_WIDTH),
      .EDGE_MODE (EDGE_MODE)
    ) u_ch (
      .CLK         (CLK),
      .RST         (RST),
      .unsync_bus  (unsync_bus[ch_lsb(g, BUS_WIDTH) +: BUS_WIDTH]),
      .bus_enable  (bus_enable[g]),
      .sync_ready  (sync_ready[g]),
      .ovr_clr     (ovr_clr[g]),
      .sync_bus    (sync_bus[ch_lsb(g, BUS_WIDTH) +: BUS_WIDTH]),
      .sync_valid  (sync_valid[g]),
      .enable_pulse(enable_pulse[g]),
      .overrun     (overrun[g])
`ifdef DATA_SYNC_OVR_CNT_EN
      ,
      .ovr_count   (ovr_count[ch_lsb(g, OVR_CNT_W) +: OVR_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_data_sync_mc.sv
// Random + directed bench for data_sync_mc: three instances (rise/fall/both)
// share stimulus and are compared against a sample-history reference model.
module tb_data_sync_mc;

  localparam int NS = 2;
  localparam int NM = 3;
  localparam int NC = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] ubus = '0;
  logic [1:0]  en = '0, rdy = '0, clr = '0;

  logic [15:0] sbus_o  [NM];
  logic [1:0]  valid_o [NM];
  logic [1:0]  pulse_o [NM];
  logic [1:0]  ovr_o   [NM];
  logic [15:0] cnt_o   [NM];

  always #5 CLK = ~CLK;

  for (genvar m = 0; m < NM; m++) begin : g_dut
    data_sync_mc #(
      .NUM_STAGES(NS),
      .BUS_WIDTH (8),
      .NUM_CH    (NC),
      .EDGE_MODE (m)
    ) u_dut (
      .CLK         (CLK),
      .RST         (RST),
      .unsync_bus  (ubus),
      .bus_enable  (en),
      .sync_ready  (rdy),
      .ovr_clr     (clr),
      .sync_bus    (sbus_o[m]),
      .sync_valid  (valid_o[m]),
      .enable_pulse(pulse_o[m]),
      .overrun     (ovr_o[m])
`ifdef DATA_SYNC_OVR_CNT_EN
      ,
      .ovr_count   (cnt_o[m])
`endif
    );
`ifndef DATA_SYNC_OVR_CNT_EN
    assign cnt_o[m] = '0;
`endif
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: h[..][0] is the most recent enable sample taken by the DUT.
  bit       h     [NM][NC][NS+1];
  bit [7:0] m_bus [NM][NC];
  bit       m_val [NM][NC];
  bit       m_ovr [NM][NC];
  int       m_cnt [NM][NC];

  function automatic bit m_pulse(input int m, input int c);
    bit s, p;
    s = h[m][c][NS-1];
    p = h[m][c][NS];
    case (m)
      0:       return s && !p;
      1:       return !s && p;
      default: return s != p;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < NM; m++)
      for (int c = 0; c < NC; c++) begin
        for (int i = 0; i <= NS; i++) h[m][c][i] = 1'b0;
        m_bus[m][c] = '0; m_val[m][c] = 1'b0; m_ovr[m][c] = 1'b0; m_cnt[m][c] = 0;
      end
  endtask

  task automatic model_edge();
    bit p, ev;
    for (int m = 0; m < NM; m++)
      for (int c = 0; c < NC; c++) begin
        p  = m_pulse(m, c);
        ev = p && m_val[m][c] && !rdy[c];
        if (p) m_bus[m][c] = ubus[c*8 +: 8];
        m_val[m][c] = p || (m_val[m][c] && !rdy[c]);
        m_ovr[m][c] = ev || (m_ovr[m][c] && !clr[c]);
        if (clr[c])                        m_cnt[m][c] = ev ? 1 : 0;
        else if (ev && m_cnt[m][c] < 255)  m_cnt[m][c]++;
        for (int i = NS; i > 0; i--) h[m][c][i] = h[m][c][i-1];
        h[m][c][0] = en[c];
      end
  endtask

  task automatic check_all();
    for (int m = 0; m < NM; m++)
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("m%0d c%0d bus", m, c),   32'(sbus_o[m][c*8 +: 8]), 32'(m_bus[m][c]));
        chk($sformatf("m%0d c%0d valid", m, c), 32'(valid_o[m][c]),      32'(m_val[m][c]));
        chk($sformatf("m%0d c%0d pulse", m, c), 32'(pulse_o[m][c]),      32'(m_pulse(m, c)));
        chk($sformatf("m%0d c%0d ovr", m, c),   32'(ovr_o[m][c]),        32'(m_ovr[m][c]));
`ifdef DATA_SYNC_OVR_CNT_EN
        chk($sformatf("m%0d c%0d cnt", m, c),   32'(cnt_o[m][c*8 +: 8]), 32'(m_cnt[m][c]));
`endif
      end
  endtask

  task automatic step();
    @(posedge CLK);
    if (RST) model_edge();
    @(negedge CLK);
    check_all();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    check_all();
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) step();

    // Latency: rising enable on ch0 with A5, consumer always ready.
    en = 2'b01; ubus = 16'h00A5; rdy = 2'b11;
    step(); chk("lat pulse e1", 32'(pulse_o[0][0]), 32'd0);
    step(); chk("lat pulse e2", 32'(pulse_o[0][0]), 32'd1);
    step(); chk("lat bus e3",   32'(sbus_o[0][7:0]), 32'hA5);
            chk("lat valid e3", 32'(valid_o[0][0]), 32'd1);
            chk("lat pulse e3", 32'(pulse_o[0][0]), 32'd0);
    step(); chk("lat valid e4", 32'(valid_o[0][0]), 32'd0);

    // Randomised traffic with occasional mid-operation resets.
    for (int t = 0; t < 1500; t++) begin
      en   = en ^ 2'(($urandom_range(0, 2) == 0) ? $urandom : 0);
      ubus = 16'($urandom);
      rdy  = 2'($urandom);
      clr  = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 299) == 0) do_reset();
      step();
    end

    // Saturation: ch1 toggles every 2 cycles with a stalled consumer; ch0 held clear.
    rdy = 2'b00; clr = 2'b01; en[0] = 1'b0;
    for (int t = 0; t < 1300; t++) begin
      if (t % 2 == 0) en[1] = ~en[1];
      ubus[15:8] = 8'(t);
      step();
    end
    chk("sat ovr c1", 32'(ovr_o[0][1]), 32'd1);
`ifdef DATA_SYNC_OVR_CNT_EN
    chk("sat cnt c1", 32'(cnt_o[0][15:8]), 32'd255);
    chk("sat cnt c0", 32'(cnt_o[0][7:0]),  32'd0);
`endif

    // Clear coincident with an overrun event: set wins, count restarts at 1.
    for (int t = 0; t < 8; t++) begin
      if (t % 2 == 0) en[1] = ~en[1];
      clr[1] = m_pulse(0, 1) && m_val[0][1];
      step();
      if (clr[1]) begin
        chk("clr+ev ovr", 32'(ovr_o[0][1]), 32'd1);
`ifdef DATA_SYNC_OVR_CNT_EN
        chk("clr+ev cnt", 32'(cnt_o[0][15:8]), 32'd1);
`endif
      end
    end
    clr = 2'b00;

    // Reset while valid and overrun are set; enable held high across release.
    en = 2'b10; rdy = 2'b00; ubus = 16'h5A00;
    step();
    RST = 1'b0;
    #1;
    chk("rst valid", 32'(valid_o[0]), 32'd0);
    chk("rst ovr",   32'(ovr_o[0]),   32'd0);
    chk("rst bus",   32'(sbus_o[0]),  32'd0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    step(); chk("rel valid e1", 32'(valid_o[0][1]), 32'd0);
    step(); chk("rel valid e2", 32'(valid_o[0][1]), 32'd0);
            chk("rel pulse e2", 32'(pulse_o[0][1]), 32'd1);
    step(); chk("rel valid e3", 32'(valid_o[0][1]), 32'd1);
            chk("rel bus e3",   32'(sbus_o[0][15:8]), 32'h5A);
    repeat (4) step();
    chk("rel one capture", 32'(ovr_o[0][1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
